// File: rtl/vec_alu_seq_if.sv
// Bundles the sequencer's request, ALU-drive and writeback signals.
// slave is the sequencer's side; master is the requester/ALU side.
interface vec_alu_seq_if #(
    parameter int VLEN = 128
);
    logic            start;
    logic            kill;
    logic [9:0]      vl;
    logic [2:0]      vsew;
    logic [VLEN-1:0] vd_old;
    logic [63:0]     alu_res;
    logic            alu_run;
    logic [9:0]      alu_index;
    logic [3:0]      alu_in_reg_offset;
    logic            busy;
    logic            done;
    logic            vd_we;
    logic [VLEN-1:0] vd_out;
    logic            err;

    modport slave (
        input  start, kill, vl, vsew, vd_old, alu_res,
        output alu_run, alu_index, alu_in_reg_offset, busy, done, vd_we, vd_out, err
    );

    modport master (
        output start, kill, vl, vsew, vd_old, alu_res,
        input  alu_run, alu_index, alu_in_reg_offset, busy, done, vd_we, vd_out, err
    );
endinterface

// File: rtl/vec_alu_seq.sv
// Walks the active chunks of a vector op through one ALU lane and collects
// the lane results into a tail-undisturbed destination register.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | one chunk per cycle issued to the ALU, result captured at the edge
// FIN   | one-cycle done / vd_we strobe
module vec_alu_seq #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3
) (
    input  logic          clk,
    input  logic          resetn,
    vec_alu_seq_if.slave  bus
);
    localparam int LW = 1 << LANE_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [9:0]      c_q, c_d;
    logic [3:0]      o_q, o_d;
    logic [3:0]      kmax_q, kmax_d;
    logic [10:0]     n_q, n_d;
    logic [2:0]      slog_q, slog_d;
    logic [VLEN-1:0] vd_q, vd_d;
    logic            err_q, err_d;

    logic [2:0]      sew_log, step_log, kshift;
    logic [10:0]     vlmax, vl_eff, n_new;
    logic            clamp, accept, last_chunk;
    logic [9:0]      bit_off;
    logic [VLEN-1:0] step_mask, lane_res;
    logic            res_unused;

    assign res_unused = ^bus.alu_res;

    // Decode of the requested op, only consumed when a start is accepted.
    always_comb begin
        sew_log  = bus.vsew + 3'd3;
        step_log = sew_log;
        kshift   = 3'd0;
        if (sew_log > 3'(LANE_WIDTH)) begin
            step_log = 3'(LANE_WIDTH);
            kshift   = sew_log - 3'(LANE_WIDTH);
        end
        vlmax  = 11'(VLEN >> sew_log);
        vl_eff = {1'b0, bus.vl};
        clamp  = 1'b0;
        if (bus.vsew > 3'd3) begin
            vl_eff = 11'd0;
            clamp  = 1'b1;
        end else if ({1'b0, bus.vl} > vlmax) begin
            vl_eff = vlmax;
            clamp  = 1'b1;
        end
        n_new = vl_eff << kshift;
    end

    assign accept     = (state_q == IDLE) && bus.start && !bus.kill;
    assign last_chunk = ({1'b0, c_q} == (n_q - 11'd1));
    assign bit_off    = c_q << slog_q;
    assign step_mask  = {VLEN{1'b1}} >> (VLEN - (1 << slog_q));
    assign lane_res   = VLEN'(bus.alu_res[LW-1:0]) & step_mask;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            c_q     <= '0;
            o_q     <= '0;
            kmax_q  <= '0;
            n_q     <= '0;
            slog_q  <= '0;
            vd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            o_q     <= o_d;
            kmax_q  <= kmax_d;
            n_q     <= n_d;
            slog_q  <= slog_d;
            vd_q    <= vd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        o_d     = o_q;
        kmax_d  = kmax_q;
        n_d     = n_q;
        slog_d  = slog_q;
        vd_d    = vd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    vd_d    = bus.vd_old;
                    c_d     = '0;
                    o_d     = '0;
                    kmax_d  = 4'((4'd1 << kshift) - 4'd1);
                    n_d     = n_new;
                    slog_d  = step_log;
                    err_d   = clamp;
                    state_d = (n_new == 11'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                // The chunk in flight is captured even when this cycle is killed.
                vd_d = (vd_q & ~(step_mask << bit_off)) | (lane_res << bit_off);
                c_d  = c_q + 10'd1;
                o_d  = (o_q == kmax_q) ? 4'd0 : o_q + 4'd1;
                if (bus.kill)
                    state_d = IDLE;
                else if (last_chunk)
                    state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.alu_run           = 1'b0;
        bus.alu_index         = '0;
        bus.alu_in_reg_offset = '0;
        bus.done              = 1'b0;
        bus.vd_we             = 1'b0;
        bus.busy              = (state_q != IDLE);
        case (state_q)
            RUN: begin
                bus.alu_run           = 1'b1;
                bus.alu_index         = bit_off;
                bus.alu_in_reg_offset = o_q;
            end
            FIN: begin
                bus.done  = !bus.kill;
                bus.vd_we = !bus.kill;
            end
            default: ;
        endcase
    end

    assign bus.vd_out = vd_q;
    assign bus.err    = err_q;
endmodule
